// File: rtl/pkt_rd_ctrl.sv
// pkt_rd_ctrl -- read-side client of the packet-cache address manager.
//
// Takes a packet ID from the output scheduler and asks the address manager for
// the slot base address. It streams the slot out of the data cache until the
// first tail word, then returns the ID to the free pool with a release pulse.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_rd_ID / _wr            packet ID from the scheduler (taken only when ready)
//   out_rd_ID_ready           idle, can accept an ID
//   out_addr_mgmt_ID / _wr    ID and request level towards the address manager
//   in_raddr / in_raddr_wr    slot base read address from the address manager
//   out_ram2addr_valid        one-cycle pulse: slot fully read, ID returned
//   ram_raddr / ram_rd        cache read port request
//   ram_rdata                 cache read data, valid RD_LAT cycles after ram_rd
//   out_data / out_data_wr    packet words towards the transmit path
//   in_data_alf               downstream almost-full, gates new reads only
//   out_pkt_cnt               packets sent (statistics build only, else 0)
//   out_trunc_cnt             slots truncated (statistics build only, else 0)
//
// Build option: define PKT_RD_STAT_EN to build the two statistics counters.
// A truncated slot ends with a forced tail word, so it also counts as a packet.
//
// ram_rd, ram_raddr and the data path are combinational so that issue reacts
// to in_data_alf and to a returning tail word in the same cycle; the control
// outputs towards the scheduler and address manager are registered.
// RD_LAT must be at least 2.

module pkt_rd_ctrl #(
  parameter int DATA_W     = 134,
  parameter int SLOT_WORDS = 128,
  parameter int RD_LAT     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_rd_ID,
  input  logic              in_rd_ID_wr,
  output logic              out_rd_ID_ready,
  output logic [7:0]        out_addr_mgmt_ID,
  output logic              out_addr_mgmt_ID_wr,
  input  logic [10:0]       in_raddr,
  input  logic              in_raddr_wr,
  output logic              out_ram2addr_valid,
  output logic [10:0]       ram_raddr,
  output logic              ram_rd,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_data_wr,
  input  logic              in_data_alf,
  output logic [31:0]       out_pkt_cnt,
  output logic [15:0]       out_trunc_cnt
);

  localparam int               CNT_W     = $clog2(SLOT_WORDS) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(SLOT_WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_WORDS - 1);
  localparam logic [1:0]       FLAG_TAIL = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_READ, S_DRAIN, S_RELEASE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        id_q, id_d;
  logic              id_wr_q, id_wr_d;
  logic              ready_q, ready_d;
  logic              rel_q, rel_d;
  logic [10:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  rcv_cnt_q, rcv_cnt_d;
  logic              done_q, done_d;
  logic [RD_LAT-1:0] vld_q, vld_d;

  logic       fwd, last_word, force_tail, tail_now, issue, release_ok;
  logic [1:0] ret_flag;

  // Return path and issue decision.
  always_comb begin
    ret_flag   = ram_rdata[DATA_W-1 -: 2];
    // Everything after the first tail of the slot is dropped.
    fwd        = vld_q[RD_LAT-1] && !done_q;
    last_word  = (rcv_cnt_q == CNT_LAST);
    force_tail = fwd && last_word && (ret_flag != FLAG_TAIL);
    tail_now   = fwd && ((ret_flag == FLAG_TAIL) || last_word);
    issue      = (state_q == S_READ) && !in_data_alf && (issue_cnt_q != CNT_FULL)
                 && !done_q && !tail_now;
    vld_d      = {vld_q[RD_LAT-2:0], issue};
    // Release once the slot has ended and at most the read returning in the
    // next cycle is still outstanding; that word is discarded on arrival.
    release_ok = (done_q || tail_now) && (vld_d[RD_LAT-2:0] == '0);
  end

  always_comb begin
    // NOTE: every always_comb target gets a default first, so no branch can leave it unassigned and infer a latch.
    state_d     = state_q;
    id_d        = id_q;
    id_wr_d     = id_wr_q;
    ready_d     = ready_q;
    rel_d       = 1'b0;
    ptr_d       = ptr_q;
    issue_cnt_d = issue_cnt_q;
    rcv_cnt_d   = rcv_cnt_q;
    done_d      = done_q | tail_now;

    if (fwd) rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
    if (issue) begin
      ptr_d       = ptr_q + 11'd1;
      issue_cnt_d = issue_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (ready_q && in_rd_ID_wr) begin
          id_d    = in_rd_ID;
          id_wr_d = 1'b1;
          ready_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (in_raddr_wr) begin
          ptr_d       = in_raddr;
          issue_cnt_d = '0;
          rcv_cnt_d   = '0;
          done_d      = 1'b0;
          state_d     = S_READ;
        end
      end
      S_READ: begin
        if (release_ok) begin
          rel_d   = 1'b1;
          state_d = S_RELEASE;
        end else if (done_d || issue_cnt_d == CNT_FULL) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (release_ok) begin
          rel_d   = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        id_wr_d = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      id_q        <= '0;
      id_wr_q     <= 1'b0;
      ready_q     <= 1'b0;
      rel_q       <= 1'b0;
      ptr_q       <= '0;
      issue_cnt_q <= '0;
      rcv_cnt_q   <= '0;
      done_q      <= 1'b0;
      vld_q       <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      id_wr_q     <= id_wr_d;
      ready_q     <= ready_d;
      rel_q       <= rel_d;
      ptr_q       <= ptr_d;
      issue_cnt_q <= issue_cnt_d;
      rcv_cnt_q   <= rcv_cnt_d;
      done_q      <= done_d;
      vld_q       <= vld_d;
    end
  end

  always_comb begin
    out_data = '0;
    if (fwd) begin
      out_data = ram_rdata;
      if (force_tail) out_data[DATA_W-1 -: 2] = FLAG_TAIL;
    end
  end

  assign out_rd_ID_ready     = ready_q;
  assign out_addr_mgmt_ID    = id_q;
  assign out_addr_mgmt_ID_wr = id_wr_q;
  assign out_ram2addr_valid  = rel_q;
  assign ram_rd              = issue;
  assign ram_raddr           = ptr_q;
  assign out_data_wr         = fwd;

`ifdef PKT_RD_STAT_EN
  logic [31:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] trunc_cnt_q, trunc_cnt_d;

  always_comb begin
    pkt_cnt_d   = pkt_cnt_q;
    trunc_cnt_d = trunc_cnt_q;
    if (tail_now) pkt_cnt_d = pkt_cnt_q + 32'd1;
    if (force_tail && trunc_cnt_q != 16'hFFFF) trunc_cnt_d = trunc_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_q   <= '0;
      trunc_cnt_q <= '0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      trunc_cnt_q <= trunc_cnt_d;
    end
  end

  assign out_pkt_cnt   = pkt_cnt_q;
  assign out_trunc_cnt = trunc_cnt_q;
`else
  assign out_pkt_cnt   = '0;
  assign out_trunc_cnt = '0;
`endif

endmodule

// File: doc/pkt_rd_ctrl.md
# pkt_rd_ctrl

Read-side client of the packet-cache address manager. It takes packet IDs chosen by the output scheduler and requests each slot's base read address from the address manager. It then streams the stored packet out of the 2048×134 data cache to the transmit path and returns the ID to the free pool once the slot is fully read. It sits between the output queue/scheduler, the address manager and the data cache read port.

## Interface
- DATA_W, 134, cache word width; bits [133:132] are the word flag: 01 head, 11 middle, 10 tail
- SLOT_WORDS, 128, words per cache slot (base address = {ID[3:0], 7'h0})
- RD_LAT, 2, cache read latency in cycles (ram_rd to ram_rdata valid)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_rd_ID  in  8  packet ID to transmit
- in_rd_ID_wr  in  1  ID strobe, honoured only while out_rd_ID_ready=1
- out_rd_ID_ready  out  1  block idle, can accept an ID
- out_addr_mgmt_ID  out  8  ID presented to address manager
- out_addr_mgmt_ID_wr  out  1  ID request level, held until release
- in_raddr  in  11  slot base read address
- in_raddr_wr  in  1  one-cycle strobe qualifying in_raddr
- out_ram2addr_valid  out  1  one-cycle pulse: slot read done, ID returned
- ram_raddr  out  11  cache read address
- ram_rd  out  1  cache read enable
- ram_rdata  in  DATA_W  cache read data, valid RD_LAT cycles after ram_rd
- out_data  out  DATA_W  packet word to transmit path
- out_data_wr  out  1  out_data valid
- in_data_alf  in  1  downstream almost-full; guarantees ≥RD_LAT+1 free words when asserted
- out_pkt_cnt  out  32  packets sent (see Configuration)
- out_trunc_cnt  out  16  slots truncated (see Configuration)

## Operation
- States: IDLE, REQ, READ, DRAIN, RELEASE.
- IDLE: ready=1. On in_rd_ID_wr, latch ID, drive out_addr_mgmt_ID, set out_addr_mgmt_ID_wr=1, ready=0, go to REQ.
- REQ: wait for in_raddr_wr. Latch in_raddr as the read pointer, clear word counters, go to READ.
- READ: each cycle with in_data_alf=0, ram_rd=1, ram_raddr=pointer, pointer+1, issue count+1. Stop issuing when issue count reaches SLOT_WORDS or a tail flag is returned. Go to DRAIN on either condition.
- Return path: RD_LAT-deep valid shift register tracks in-flight reads. A returned word is forwarded (out_data_wr=1) only until and including the first tail word. Words returned after the tail are discarded. If word SLOT_WORDS returns without a tail flag, it is forwarded with bits [133:132] forced to 10 and the slot is counted as truncated.
- DRAIN: wait until no reads are in flight, then go to RELEASE.
- RELEASE: pulse out_ram2addr_valid=1 for one cycle with out_addr_mgmt_ID stable. The next cycle drops out_addr_mgmt_ID_wr, sets ready=1 and returns to IDLE.
- Pointer arithmetic is 11-bit. It never leaves the slot because the issue count is capped at SLOT_WORDS.

## Timing
- Reset values: out_rd_ID_ready=0 during reset and 1 the cycle after. out_addr_mgmt_ID=0, out_addr_mgmt_ID_wr=0, out_ram2addr_valid=0, ram_raddr=0, ram_rd=0, out_data=0, out_data_wr=0, counters=0.
- in_rd_ID_wr at cycle T: out_addr_mgmt_ID_wr=1 at T+1.
- in_raddr_wr at cycle R: first ram_rd at R+1, first out_data_wr at R+1+RD_LAT.
- Tail word out at cycle E: out_ram2addr_valid at E+1 (in-flight reads drained by then), ID_wr low at E+2, ready=1 at E+2.
- out_addr_mgmt_ID and out_addr_mgmt_ID_wr stay stable from request through the release pulse. The manager captures the ID on the release pulse.
- in_rd_ID_wr while ready=0 is ignored. in_raddr_wr outside REQ is ignored.
- in_data_alf only gates issue. In-flight words are always forwarded and never stall.
- Reset mid-packet: all state is cleared immediately. The held ID is not returned; the address manager is reset in the same domain.

## Configuration
- PKT_RD_STAT_EN defined: out_pkt_cnt increments on each forwarded tail word and wraps at 2^32. out_trunc_cnt increments per truncated slot and saturates at 16'hFFFF.
- PKT_RD_STAT_EN undefined: both ports are tied to 0 and no counter logic is built.

## Test plan
- Single 4-word packet, ID 8'h05, raddr 11'h280: reads at 280..283. 4 words out with flags 01,11,11,10. Release pulse 1 cycle after the tail. ID_wr drops the next cycle. out_pkt_cnt=1.
- 1-word packet (flag 10): exactly 1 word out, speculative extra reads discarded, release follows with ID unchanged.
- No tail in slot ID 8'h0F: 128 reads 780..7FF. Word 128 is output with flag 10. out_trunc_cnt=1. Pointer does not pass 7FF.
- in_data_alf toggling every 3 cycles during a 20-word packet: ram_rd is gated, all 20 words arrive in order with no loss or duplication.
- in_rd_ID_wr asserted while busy and a stray in_raddr_wr in READ: both ignored, current packet unaffected.
- rst asserted mid-READ: all outputs return to reset values next cycle. A new ID is accepted after reset and sent correctly.
